// File: rtl/lsu_pkg.sv
// Shared constants for the load/store sequencer: funct3 codes, mutator commands,
// FSM states and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] CMD_WORD    = 3'b000;
    localparam logic [2:0] CMD_ZERO    = 3'b001;
    localparam logic [2:0] CMD_HALF_LO = 3'b010;
    localparam logic [2:0] CMD_HALF_HI = 3'b011;
    localparam logic [2:0] CMD_BYTE0   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // True when the request must be answered with an error and no memory access.
    function automatic logic req_is_bad(input logic we, input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        illegal    = we ? (f3 > F3_W) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        misaligned = (f3[1:0] == 2'b01 && addr_lo[0]) || (f3[1:0] == 2'b10 && addr_lo != 2'b00);
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// Bundle of core request, memory port, mutator and response signals.
// The sequencer uses the slave modport; the core/memory environment uses master.
interface lsu_sequencer_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    logic [2:0]        mut_command;
    logic [31:0]       mut_data;
    logic [31:0]       mut_q;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_ack, mem_rdata, mut_q,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mut_command, mut_data, resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_ack, mem_rdata, mut_q,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mut_command, mut_data, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_store_align.sv
// Combinational lane steering: byte enables, replicated store data and the
// mutator command for a load, derived from funct3 and the low address bits.
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [2:0]  cmd_o
);

    // NOTE: every output gets a default first so no path through the cases infers a latch.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        cmd_o   = CMD_WORD;
        if (we_i) begin
            cmd_o = CMD_ZERO;
            case (funct3_i[1:0])
                2'b00: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                default: ;
            endcase
        end else begin
            case (funct3_i[1:0])
                2'b00:   cmd_o = {CMD_BYTE0[2], addr_lo_i};
                2'b01:   cmd_o = addr_lo_i[1] ? CMD_HALF_HI : CMD_HALF_LO;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: one request at a time, single word access with req/ack,
// load data returned through the external mutator. Optional macro LSU_TIMEOUT_EN
// bounds the wait for mem_ack to TIMEOUT_CYCLES cycles.
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    lsu_sequencer_if.slave bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [31:0]       mdata_q, mdata_d;

    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [2:0]        al_cmd;
    logic              bad_req;
    logic              timed_out;

    lsu_store_align u_align (
        .we_i      (bus.req_we),
        .funct3_i  (bus.req_funct3),
        .addr_lo_i (bus.req_addr[1:0]),
        .wdata_i   (bus.req_wdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .cmd_o     (al_cmd)
    );

    assign bad_req = req_is_bad(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_ACCESS) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // cnt_q counts completed ACCESS cycles, so mem_req stays up exactly TIMEOUT_CYCLES cycles.
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        err_d   = err_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cmd_d   = cmd_q;
        mdata_d = mdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d  = bus.req_we;
                    f3_d  = bus.req_funct3;
                    err_d = bad_req;
                    if (bad_req) begin
                        cmd_d   = CMD_ZERO;
                        state_d = ST_RESP;
                    end else begin
                        cmd_d   = al_cmd;
                        addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        be_d    = al_be;
                        wdata_d = al_wdata;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (bus.mem_ack) begin
                    mdata_d = bus.mem_rdata;
                    state_d = ST_RESP;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            err_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            cmd_q   <= CMD_ZERO;
            mdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cmd_q   <= cmd_d;
            mdata_q <= mdata_d;
        end
    end

    // Strobes decode straight from the state so an async reset drops mem_req at once.
    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.mem_req     = (state_q == ST_ACCESS);
    assign bus.mem_we      = (state_q == ST_ACCESS) && we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_be      = be_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mut_command = cmd_q;
    assign bus.mut_data    = mdata_q;
    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.resp_err    = (state_q == ST_RESP) && err_q;

    always_comb begin
        bus.resp_rdata = 32'h0;
        if (state_q == ST_RESP && !err_q && !we_q) begin
            case (f3_q)
                F3_B:    bus.resp_rdata = {{24{bus.mut_q[7]}}, bus.mut_q[7:0]};
                F3_H:    bus.resp_rdata = {{16{bus.mut_q[15]}}, bus.mut_q[15:0]};
                default: bus.resp_rdata = bus.mut_q;
            endcase
        end
    end

endmodule
